// File: rtl/sort4_unit.sv
// sort4_unit: collects a batch of four 6-bit elements, sorts them in place
// with a fixed 9-cycle bubble sort (signed or unsigned compare chosen by the
// first element of the batch), then streams them out in ascending order
// under valid/ready handshaking.
// Optional feature: define SORT4_DUP_FLAG_EN to add the out_dup output,
// which flags an output element equal to the one streamed before it.
module sort4_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    input  logic       in_signed,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_data,
    output logic       out_last,
    output logic       busy
`ifdef SORT4_DUP_FLAG_EN
    ,
    output logic       out_dup
`endif
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  slot_q [4];
    logic [1:0]  load_idx_q;   // next slot to fill in LOAD
    logic [1:0]  k_q;          // next slot to emit in DRAIN
    logic [1:0]  pass_q;       // bubble pass 0..2
    logic [1:0]  pair_q;       // compared pair (pair_q, pair_q+1), 0..2
    logic        mode_q;       // 1 = signed compare for the current batch

    logic [1:0]  pair_hi;
    logic [5:0]  cmp_lo, cmp_hi;
    logic        do_swap;
    logic        sort_done;

    // Compare the active pair; swap only on strict less-than so equal
    // elements keep their order and never cause a needless swap.
    always_comb begin
        pair_hi   = pair_q + 2'd1;
        cmp_lo    = slot_q[pair_q];
        cmp_hi    = slot_q[pair_hi];
        do_swap   = mode_q ? ($signed(cmp_hi) < $signed(cmp_lo)) : (cmp_hi < cmp_lo);
        sort_done = (pass_q == 2'd2) && (pair_q == 2'd2);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Next-state and handshake/output decode.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 6'h00;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (load_idx_q == 2'd3)) state_d = SORT;
            end
            SORT: begin
                busy = 1'b1;
                if (sort_done) state_d = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = slot_q[k_q];
                out_last  = (k_q == 2'd3);
                if (out_ready && (k_q == 2'd3)) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

`ifdef SORT4_DUP_FLAG_EN
    logic [1:0] k_prev;

    // Flag an emitted element equal to its predecessor in sorted order.
    always_comb begin
        k_prev  = k_q - 2'd1;
        out_dup = (state_q == DRAIN) && (k_q != 2'd0) && (slot_q[k_q] == slot_q[k_prev]);
    end
`endif

    // Datapath: slot loading, in-place compare/swap, drain index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the slot storage is reset explicitly so a batch cut short
            // by reset can never leak stale elements into a later output.
            for (int i = 0; i < 4; i++) slot_q[i] <= 6'h00;
            load_idx_q <= 2'd0;
            k_q        <= 2'd0;
            pass_q     <= 2'd0;
            pair_q     <= 2'd0;
            mode_q     <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    pass_q <= 2'd0;
                    pair_q <= 2'd0;
                    k_q    <= 2'd0;
                    if (in_valid) begin
                        slot_q[load_idx_q] <= in_data;
                        if (load_idx_q == 2'd0) mode_q <= in_signed;
                        // Wraps 3 -> 0, ready for the next batch.
                        load_idx_q <= load_idx_q + 2'd1;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        slot_q[pair_q]  <= cmp_hi;
                        slot_q[pair_hi] <= cmp_lo;
                    end
                    if (pair_q == 2'd2) begin
                        pair_q <= 2'd0;
                        pass_q <= (pass_q == 2'd2) ? 2'd0 : pass_q + 2'd1;
                    end else begin
                        pair_q <= pair_q + 2'd1;
                    end
                end
                DRAIN: begin
                    // Wraps 3 -> 0 on the final transfer.
                    if (out_ready) k_q <= k_q + 2'd1;
                end
                default: begin
                    load_idx_q <= 2'd0;
                    k_q        <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_unit.sv
// tb_sort4_unit: self-checking bench for sort4_unit. Directed batches from
// the requirements plus randomized batches (random gaps, random backpressure)
// compared against a behavioural sorting model. Define SORT4_DUP_FLAG_EN to
// also check out_dup.
module tb_sort4_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_signed = 1'b0;
    logic [5:0] in_data = 6'h00;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_last, busy;
    logic [5:0] out_data;
`ifdef SORT4_DUP_FLAG_EN
    logic       out_dup;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_xfer  = 0;

    sort4_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef SORT4_DUP_FLAG_EN
        ,
        .out_dup   (out_dup)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Numeric value of an element under the given compare mode.
    function automatic int key(input logic [5:0] v, input logic s);
        if (s && v[5]) return int'(v) - 64;
        return int'(v);
    endfunction

    // Reference: repeatedly pull the smallest remaining element.
    task automatic ref_sort(input logic [5:0] v [4], input logic s, output logic [5:0] o [4]);
        logic [5:0] pool [$];
        pool = {v[0], v[1], v[2], v[3]};
        for (int n = 0; n < 4; n++) begin
            int m = 0;
            for (int i = 1; i < pool.size(); i++)
                if (key(pool[i], s) < key(pool[m], s)) m = i;
            o[n] = pool[m];
            pool.delete(m);
        end
    endtask

    // Random element, biased toward the sign/range boundaries.
    function automatic logic [5:0] pick();
        logic [5:0] edges [6];
        edges = '{6'h00, 6'h01, 6'h1F, 6'h20, 6'h3E, 6'h3F};
        if ($urandom_range(0, 1) == 0) return edges[$urandom_range(0, 5)];
        return 6'($urandom);
    endfunction

    // Send four elements; later elements carry the opposite mode bit, which
    // must be ignored. Records the cycle of the slot-3 transfer.
    task automatic send(input logic [5:0] v [4], input logic s, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            int g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            int w = 0;
            repeat (g) begin
                in_valid  = 1'b0;
                in_data   = 6'($urandom);
                in_signed = 1'($urandom);
                step();
            end
            in_valid  = 1'b1;
            in_data   = v[i];
            in_signed = (i == 0) ? s : ~s;
            while (!in_ready && w < 20) begin
                step();
                w++;
            end
            if (w == 20) check("in_ready_timeout", 32'd0, 32'd1);
            if (i == 3) t_xfer = cyc;
            step();
        end
        in_valid = 1'b0;
        in_data  = 6'h00;
    endtask

    // Collect four outputs and compare with exp; optional 5-cycle stall at k=1.
    task automatic recv(input logic [5:0] exp [4], input bit stall_k1, input bit rnd_stall);
        int  j = 0;
        int  w = 0;
        int  stalls = 0;
        bit  first = 1'b1;
        while (j < 4 && w < 200) begin
            if (!out_valid) begin
                out_ready = 1'($urandom);
                check("idle_out_data", 32'(out_data), 32'd0);
                check("sort_in_ready", 32'(in_ready), 32'd0);
                check("sort_busy", 32'(busy), 32'd1);
            end else begin
                if (first) begin
                    check("latency", 32'(cyc - t_xfer), 32'd10);
                    first = 1'b0;
                end
                if (stall_k1 && j == 1 && stalls < 5) begin
                    out_ready = 1'b0;
                    stalls++;
                end else if (rnd_stall) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    out_ready = 1'b1;
                end
                check($sformatf("out_data[%0d]", j), 32'(out_data), 32'(exp[j]));
                check($sformatf("out_last[%0d]", j), 32'(out_last), 32'(j == 3));
                check("drain_in_ready", 32'(in_ready), 32'd0);
`ifdef SORT4_DUP_FLAG_EN
                check($sformatf("out_dup[%0d]", j), 32'(out_dup),
                      32'((j > 0) ? (exp[j] == exp[j - 1]) : 1'b0));
`endif
                if (out_ready) j++;
            end
            step();
            w++;
        end
        if (j < 4) check("drain_timeout", 32'(j), 32'd4);
        out_ready = 1'b0;
        // Back in LOAD right after the final transfer.
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
        check("post_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef SORT4_DUP_FLAG_EN
        check({tag, "_out_dup"}, 32'(out_dup), 32'd0);
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges; released 1 unit
    // after a rising edge so the next edge can take a slot-0 transfer.
    task automatic reset_pulse(input string tag);
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs(tag);
        step();
        rst_n = 1'b1;
    endtask

    logic [5:0] a [4];
    logic [5:0] e [4];

    initial begin
        // Reset state.
        #2;
        check_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;

        // Unsigned directed batch.
        a = '{6'h05, 6'h03, 6'h3F, 6'h00};
        e = '{6'h00, 6'h03, 6'h05, 6'h3F};
        send(a, 1'b0, 0);
        recv(e, 1'b0, 1'b0);

        // Signed directed batch.
        a = '{6'h05, 6'h03, 6'h3F, 6'h20};
        e = '{6'h20, 6'h3F, 6'h03, 6'h05};
        send(a, 1'b1, 0);
        recv(e, 1'b0, 1'b0);

        // Duplicates.
        a = '{6'h07, 6'h07, 6'h02, 6'h07};
        e = '{6'h02, 6'h07, 6'h07, 6'h07};
        send(a, 1'b0, 0);
        recv(e, 1'b0, 1'b0);

        // Long stall at k=1, then a back-to-back batch with no idle cycle.
        a = '{6'h3F, 6'h10, 6'h01, 6'h2A};
        e = '{6'h01, 6'h10, 6'h2A, 6'h3F};
        send(a, 1'b0, 0);
        recv(e, 1'b1, 1'b0);
        a = '{6'h3F, 6'h10, 6'h01, 6'h2A};
        e = '{6'h2A, 6'h3F, 6'h01, 6'h10};
        send(a, 1'b1, 0);
        recv(e, 1'b0, 1'b0);

        // Randomized batches with input gaps and output backpressure.
        for (int b = 0; b < 25; b++) begin
            logic s;
            s = 1'($urandom);
            for (int i = 0; i < 4; i++) a[i] = pick();
            ref_sort(a, s, e);
            send(a, s, 2);
            recv(e, 1'b0, 1'b1);
        end

        // Reset during SORT cycle 4, then a fresh batch.
        a = '{6'h3F, 6'h3E, 6'h3D, 6'h3C};
        send(a, 1'b0, 0);
        step();
        step();
        step();
        reset_pulse("rst_sort");
        a = '{6'h01, 6'h00, 6'h00, 6'h00};
        e = '{6'h00, 6'h00, 6'h00, 6'h01};
        send(a, 1'b0, 0);
        recv(e, 1'b0, 1'b0);

        // Reset mid-DRAIN after one element, then a fresh signed batch.
        a = '{6'h11, 6'h22, 6'h33, 6'h04};
        send(a, 1'b0, 0);
        begin
            int w = 0;
            while (!out_valid && w < 30) begin
                step();
                w++;
            end
            if (w == 30) check("drain_wait_timeout", 32'd0, 32'd1);
        end
        out_ready = 1'b1;
        step();
        reset_pulse("rst_drain");
        check("rst_drain_idle_out_valid", 32'(out_valid), 32'd0);
        a = '{6'h02, 6'h30, 6'h01, 6'h1F};
        ref_sort(a, 1'b1, e);
        send(a, 1'b1, 1);
        recv(e, 1'b0, 1'b1);

        // Reset mid-LOAD after two elements.
        in_valid = 1'b1;
        in_data  = 6'h3F;
        step();
        in_data  = 6'h3F;
        step();
        reset_pulse("rst_load");
        a = '{6'h09, 6'h08, 6'h07, 6'h06};
        e = '{6'h06, 6'h07, 6'h08, 6'h09};
        send(a, 1'b0, 0);
        recv(e, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sort4_unit.md
SORT4_UNIT -- requirements
Module: sort4_unit

Interface
REQ-001 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have in_valid  input  1  in_data/in_signed valid this cycle.
REQ-004 SHALL have in_ready  output  1  block accepts input this cycle.
REQ-005 SHALL have in_data  input  6  element to sort.
REQ-006 SHALL have in_signed  input  1  compare mode: 1 signed (two's complement), 0 unsigned; sampled with the first element of a batch.
REQ-007 SHALL have out_valid  output  1  out_data valid.
REQ-008 SHALL have out_ready  input  1  downstream accepts output.
REQ-009 SHALL have out_data  output  6  sorted element, ascending order.
REQ-010 SHALL have out_last  output  1  high with the fourth (final) output element.
REQ-011 SHALL have busy  output  1  high in SORT or DRAIN.

Function
REQ-012 SHALL sort batches of exactly four 6-bit elements, ascending, using a 3-state FSM: LOAD, SORT, DRAIN.
REQ-013 LOAD: in_ready=1; a transfer occurs when in_valid&&in_ready; elements are written to slots 0..3 in arrival order.
REQ-014 in_signed SHALL be latched on the slot-0 transfer and held for the whole batch; in_signed on later transfers is ignored.
REQ-015 After the slot-3 transfer, the FSM SHALL enter SORT on the next edge; in_ready SHALL be 0 outside LOAD.
REQ-016 SORT SHALL be a fixed 9-cycle bubble sort: 3 passes, each comparing pairs (0,1), (1,2), (2,3), one pair per cycle.
REQ-017 A pair SHALL be swapped iff slot[i+1] < slot[i] under the latched mode; equal elements SHALL NOT be swapped.
REQ-018 Signed compare SHALL treat bit 5 as sign (6'h3F = -1 < 6'h00); unsigned compare SHALL treat 6'h3F = 63.
REQ-019 After the 9th compare cycle, the FSM SHALL enter DRAIN; latency from the slot-3 transfer to the first out_valid SHALL be 10 cycles.
REQ-020 DRAIN: out_valid=1 and out_data=slot[k], k starting at 0; k advances only when out_valid&&out_ready.
REQ-021 out_last SHALL be 1 iff in DRAIN and k==3.
REQ-022 The transfer with k==3 SHALL return the FSM to LOAD on the next edge, with the slot index cleared; in_ready is 1 in that next cycle.
REQ-023 out_data SHALL hold stable while out_valid&&!out_ready (backpressure of any length).
REQ-024 in_valid gaps during LOAD SHALL leave the slot index unchanged.
REQ-025 out_valid SHALL be 0 in LOAD and SORT; out_data SHALL be 6'h00 when out_valid=0.

Reset
REQ-026 rst_n low SHALL immediately force state LOAD, slot index 0, k 0, pass/pair counters 0, latched mode 0, all slots 6'h00.
REQ-027 Reset values: in_ready=1, out_valid=0, out_data=6'h00, out_last=0, busy=0 (out_dup=0 when present).
REQ-028 Reset asserted mid-LOAD, mid-SORT or mid-DRAIN SHALL discard the partial batch; no element of it is output after reset release.
REQ-029 The first rising edge with rst_n high SHALL be able to accept a slot-0 transfer.

Configuration
REQ-030 Macro SORT4_DUP_FLAG_EN: when defined, the block SHALL add output out_dup (1 bit), high in DRAIN iff k>0 and slot[k]==slot[k-1]; otherwise 0.
REQ-031 Without SORT4_DUP_FLAG_EN, the port out_dup and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Unsigned batch 5,3,3F,0 (in_signed=0), out_ready=1 -> outputs 00,03,05,3F; out_last on 3F; first out_valid 10 cycles after the last input transfer.
REQ-033 Signed batch 5,3,3F,20 (in_signed=1) -> outputs 20,3F,03,05 (-32,-1,3,5).
REQ-034 Batch 7,7,2,7 with SORT4_DUP_FLAG_EN -> outputs 02,07,07,07; out_dup = 0,0,1,1.
REQ-035 DRAIN with out_ready held low 5 cycles at k=1 -> out_data stable at the k=1 value, no element lost or repeated; then back-to-back batches with no idle cycle between out_last and the next slot-0 transfer.
REQ-036 rst_n pulsed low during the SORT cycle 4 of a batch, then new batch 1,0,0,0 -> outputs exactly 00,00,00,01; no stale data.
